// File: rtl/reg_transfer_controller_if.sv
// rtl/reg_transfer_controller_if.sv - command handshake and register-bank control bundle
interface reg_transfer_controller_if #(
   parameter int NUM_REGS  = 4,
   parameter int SEL_WIDTH = 2
);
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_op;
   logic [SEL_WIDTH-1:0] req_src;
   logic [SEL_WIDTH-1:0] req_dst;
   logic [NUM_REGS-1:0]  reg_en;
   logic                 reg_read;
   logic                 reg_write;
   logic [1:0]           bus_mode;
   logic [SEL_WIDTH-1:0] bus_reg_sel;
   logic                 done;
   logic                 error;

   modport master (
      output req_valid, req_op, req_src, req_dst,
      input  req_ready, reg_en, reg_read, reg_write, bus_mode, bus_reg_sel, done, error
   );

   modport slave (
      input  req_valid, req_op, req_src, req_dst,
      output req_ready, reg_en, reg_read, reg_write, bus_mode, bus_reg_sel, done, error
   );
endinterface

// File: rtl/reg_transfer_controller.sv
// rtl/reg_transfer_controller.sv - sequences MOVE/LOAD/CLEAR transfers over a shared register bus
module reg_transfer_controller #(
   parameter int NUM_REGS  = 4,
   parameter int SEL_WIDTH = 2
) (
   input logic                  clock,
   input logic                  reset,
   reg_transfer_controller_if.slave ctrl
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_MOVE, OP_LOAD, OP_CLEAR} op_t;

   localparam logic [NUM_REGS-1:0] EN_ONE = NUM_REGS'(1);

   state_t               state, state_nxt;
   logic [SEL_WIDTH-1:0] src_q, dst_q, src_nxt, dst_nxt;
   logic [NUM_REGS-1:0]  en_nxt;
   logic                 read_nxt, write_nxt, done_nxt, error_nxt;
   logic [1:0]           mode_nxt;
   logic [SEL_WIDTH-1:0] sel_nxt;
   op_t                  op;
   logic                 src_ok, dst_ok, cmd_ok;

   assign op     = op_t'(ctrl.req_op);
   assign src_ok = int'(ctrl.req_src) < NUM_REGS;
   assign dst_ok = int'(ctrl.req_dst) < NUM_REGS;
   assign ctrl.req_ready = reset && (state == IDLE);

   // Only the index fields an op actually uses are range-checked.
   always_comb begin
      case (op)
         OP_NOP:  cmd_ok = 1'b1;
         OP_MOVE: cmd_ok = src_ok && dst_ok;
         default: cmd_ok = dst_ok;
      endcase
   end

   always_comb begin
      state_nxt = state;
      src_nxt   = src_q;
      dst_nxt   = dst_q;
      en_nxt    = '0;
      read_nxt  = 1'b0;
      write_nxt = 1'b0;
      done_nxt  = 1'b0;
      error_nxt = 1'b0;
      mode_nxt  = ctrl.bus_mode;
      sel_nxt   = ctrl.bus_reg_sel;
      case (state)
         IDLE: begin
            if (ctrl.req_valid) begin
               src_nxt = ctrl.req_src;
               dst_nxt = ctrl.req_dst;
               if (!cmd_ok) begin
                  error_nxt = 1'b1;
               end else begin
                  case (op)
                     OP_MOVE: begin
                        if (ctrl.req_src == ctrl.req_dst) begin
                           state_nxt = DONE;
                           done_nxt  = 1'b1;
                        end else begin
                           state_nxt = READ;
                           en_nxt    = EN_ONE << ctrl.req_src;
                           read_nxt  = 1'b1;
                           mode_nxt  = 2'd2;
                           sel_nxt   = ctrl.req_src;
                        end
                     end
                     OP_LOAD, OP_CLEAR: begin
                        state_nxt = WRITE;
                        en_nxt    = EN_ONE << ctrl.req_dst;
                        write_nxt = 1'b1;
                        mode_nxt  = (op == OP_LOAD) ? 2'd1 : 2'd0;
                     end
                     default: begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                     end
                  endcase
               end
            end
         end
         // The bus keeps the source register selected so the write captures what READ drove.
         READ: begin
            state_nxt = WRITE;
            en_nxt    = EN_ONE << dst_q;
            write_nxt = 1'b1;
            mode_nxt  = 2'd2;
            sel_nxt   = src_q;
         end
         WRITE: begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state            <= IDLE;
         src_q            <= '0;
         dst_q            <= '0;
         ctrl.reg_en      <= '0;
         ctrl.reg_read    <= 1'b0;
         ctrl.reg_write   <= 1'b0;
         ctrl.bus_mode    <= 2'd0;
         ctrl.bus_reg_sel <= '0;
         ctrl.done        <= 1'b0;
         ctrl.error       <= 1'b0;
      end else begin
         state            <= state_nxt;
         src_q            <= src_nxt;
         dst_q            <= dst_nxt;
         ctrl.reg_en      <= en_nxt;
         ctrl.reg_read    <= read_nxt;
         ctrl.reg_write   <= write_nxt;
         ctrl.bus_mode    <= mode_nxt;
         ctrl.bus_reg_sel <= sel_nxt;
         ctrl.done        <= done_nxt;
         ctrl.error       <= error_nxt;
      end
   end
endmodule

// File: doc/reg_transfer_controller.md
Name: reg_transfer_controller

Overview:
- Sequencer for a bank of register_N instances sharing one data bus.
- Accepts one transfer command at a time and issues the one-hot enable and broadcast read/write strobes the registers need: MOVE (reg to reg), LOAD (external value to reg), CLEAR (zero to reg).
- Drives the bus source select for the bus mux.
- Sits between the instruction decoder and the register bank.

Parameters:
- NUM_REGS, 4, number of registers in the bank (2..16).
- SEL_WIDTH, 2, width of register index fields; 2**SEL_WIDTH >= NUM_REGS.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  controller can accept a command.
- req_op  in  2  0=NOP, 1=MOVE, 2=LOAD, 3=CLEAR.
- req_src  in  SEL_WIDTH  source register index (MOVE only).
- req_dst  in  SEL_WIDTH  destination register index.
- reg_en  out  NUM_REGS  one-hot register enable.
- reg_read  out  1  broadcast read strobe.
- reg_write  out  1  broadcast write strobe.
- bus_mode  out  2  bus mux source: 0=zero, 1=external input, 2=register output.
- bus_reg_sel  out  SEL_WIDTH  register whose output drives the bus when bus_mode=2.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse, command rejected.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; reg_en=0, reg_read=0, reg_write=0, bus_mode=0, bus_reg_sel=0, done=0, error=0.
  - req_ready is 0 while reset=0.
  - Reset overrides any in-flight command, which is dropped with no done pulse.
  - Strobes go low on the same edge.
- States: IDLE, READ, WRITE, DONE.
- Command latching:
  - req_ready=1 only in IDLE, and reset=1.
  - A command is accepted on the edge where req_valid and req_ready are both 1.
  - op/src/dst are latched at that edge; inputs are ignored afterwards until the next IDLE.
- Accepted-command transitions:
  - MOVE, valid indices, src!=dst: IDLE -> READ -> WRITE -> DONE -> IDLE.
  - LOAD: IDLE -> WRITE -> DONE -> IDLE.
  - CLEAR: IDLE -> WRITE -> DONE -> IDLE.
  - NOP: IDLE -> DONE -> IDLE.
  - MOVE with src==dst: IDLE -> DONE -> IDLE; no strobes, done pulses.
  - Any index >= NUM_REGS in a used field: IDLE -> IDLE, error=1 for the next cycle only, no strobes, no done. req_ready stays 1 during that cycle.
- Outputs per state, all registered:
  - READ: reg_en=1<<src, reg_read=1, reg_write=0, bus_mode=2, bus_reg_sel=src.
  - WRITE: reg_en=1<<dst, reg_write=1, reg_read=0.
    - bus_mode=2 with bus_reg_sel=src for MOVE, so the bus holds the value driven in READ.
    - bus_mode=1 for LOAD; bus_mode=0 for CLEAR.
  - DONE: reg_en=0, strobes=0, done=1; bus_mode and bus_reg_sel hold their last values.
  - IDLE: reg_en=0, strobes=0, done=0; bus_mode and bus_reg_sel hold their last values.
- Latency, measured from the accept edge to the done-high cycle: MOVE 3 cycles; LOAD and CLEAR 2 cycles; NOP and self-MOVE 1 cycle.
- Throughput: a new command can be accepted on the edge where DONE exits to IDLE + 1 cycle. req_ready asserts in the cycle after done.
- Invariants:
  - reg_en is never multi-hot.
  - reg_read and reg_write are never both 1.
  - reg_read or reg_write high implies reg_en != 0.
- Unused index fields (src for LOAD/CLEAR/NOP, dst for NOP) are not range-checked.

Test Plan:
- Reset, then hold reset=0 for 2 cycles during a MOVE READ state -> all strobes 0 on the next edge, state IDLE, no done; after reset=1, req_ready=1.
- With 8-bit registers, preload r1=0xDE via LOAD (external bus 0xDE), then MOVE src=1 dst=2:
  - READ cycle: reg_en=0b0010, reg_read=1.
  - WRITE cycle: reg_en=0b0100, reg_write=1, bus_mode=2.
  - done 3 cycles after accept; r2 reads 0xDE.
- CLEAR dst=2 after r2=0xDE -> WRITE cycle with bus_mode=0, reg_en=0b0100; r2=0x00; done 2 cycles after accept.
- MOVE src=3 dst=3 -> no strobes, done 1 cycle after accept.
- NUM_REGS=3, LOAD dst=3 -> error for 1 cycle, no done, register contents unchanged.
- Back-to-back:
  - req_valid held high with LOAD dst=0 then MOVE 0->1 -> second accept occurs 1 cycle after the first done.
  - req_ready=0 in every non-IDLE cycle.
  - The checker confirms the strobe invariants every cycle.
